cache_mem_arbiter: RTL

- Shares the single RAM port between the icache (read-only) and the dcache (read/write, two-word fills and writebacks).
- Grants the port one word-transaction at a time and forwards request and response signals for the owner only.
- dcache has priority; a bounded-streak rule prevents icache starvation.
- Sits between the two caches and the RAM model/controller, with flat ports.

---
 rtl/cache_mem_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between the icache (reads) and the dcache (reads and
// writes). One word transaction at a time; dcache has priority, with a
// bounded-streak rule so a pending icache read cannot be starved.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrating, nothing driven to RAM
// IGNT  | icache owns the RAM port
// DGNT  | dcache owns the RAM port
module cache_mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} owner_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    owner_t     owner_q, owner_d;
    logic [3:0] streak_q, streak_d;
    logic       d_req, i_done, d_done;

    // The streak passed in is the post-update value, so the icache is forced
    // right after the MAX_DSTREAK-th dcache word rather than one word later.
    function automatic owner_t arb(input logic i_req, input logic dc_req,
                                   input logic [3:0] streak);
        if (i_req && streak == STREAK_MAX) return IGNT;
        else if (dc_req)                  return DGNT;
        else if (i_req)                   return IGNT;
        else                              return IDLE;
    endfunction

    assign iload  = ramload;
    assign dload  = ramload;
    assign d_req  = dREN | dWEN;
    assign i_done = (owner_q == IGNT) && iREN && (ramstate == RAM_ACCESS);
    assign d_done = (owner_q == DGNT) && d_req && (ramstate == RAM_ACCESS);

    // Streak bookkeeping: saturating count of dcache words while icache waits.
    always_comb begin
        streak_d = streak_q;
        if (!iREN || i_done)
            streak_d = 4'd0;
        else if (d_done && streak_q < STREAK_MAX)
            streak_d = streak_q + 4'd1;
    end

    // Owner outputs and next owner; address/data forwarded combinationally.
    always_comb begin
        owner_d  = owner_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (owner_q)
            IDLE: owner_d = arb(iREN, d_req, streak_d);
            IGNT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (i_done) begin
                        iwait   = 1'b0;
                        owner_d = arb(iREN, d_req, streak_d);
                    end
                end else begin
                    owner_d = arb(iREN, d_req, streak_d);
                end
            end
            DGNT: begin
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr;
                    ramstore = dstore;
                end else if (dREN) begin
                    ramREN  = 1'b1;
                    ramaddr = daddr;
                end
                if (!d_req || d_done)
                    owner_d = arb(iREN, d_req, streak_d);
                if (d_done)
                    dwait = 1'b0;
            end
            default: owner_d = IDLE;
        endcase
    end

    // Owner and streak registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner_q  <= IDLE;
            streak_q <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

endmodule
